// File: rtl/synapse_mem_pkg.sv
// synapse_mem_pkg: shared FSM states, weight-memory constants and response codes
package synapse_mem_pkg;
  typedef enum logic [1:0] {IDLE, CFG, BURST, DRAIN} fetch_state_t;
  localparam int NUM_SYNAPSES_DEFAULT = 72401;
  localparam int WEIGHT_W = 16;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req : request vector        ptr : highest-priority index
//   gnt : one-hot grant         idx : granted index      any : some request present
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan farthest-to-nearest so the nearest requester is the last (winning) write
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        gnt = N'(1) << ((int'(ptr) + i) % N);
        idx = W'((int'(ptr) + i) % N);
        any = 1'b1;
      end
  end
endmodule

// File: rtl/synapse_fetch_scheduler.sv
// synapse_fetch_scheduler: shares the single-port weight RAM between config writes and per-core burst reads
//   cfg_*  : config write request/accept/error
//   req_*  : per-port burst requests (packed, port 0 in LSBs)
//   rsp_*  : tagged weight beats from a 2-entry output buffer
//   mem_*  : RAM enable/write-enable/address/data; mem_rdata arrives one cycle after a read
module synapse_fetch_scheduler
  import synapse_mem_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_SYNAPSES = NUM_SYNAPSES_DEFAULT,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = WEIGHT_W,
  parameter int LEN_W        = 8,
  parameter int PORT_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ADDR_W-1:0]           cfg_addr,
  input  logic [DATA_W-1:0]           cfg_data,
  output logic                        cfg_err,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_base,
  input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [PORT_W-1:0]           rsp_port,
  output logic                        rsp_last,
  output logic                        rsp_err,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam logic [ADDR_W:0] NSYN = (ADDR_W + 1)'(NUM_SYNAPSES);
  fetch_state_t state_q, state_d;
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d, port_q, port_d, gnt_idx;
  logic [NUM_PORTS-1:0] gnt;
  logic gnt_any;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, new_len;
  logic inf_v_q, inf_v_d, inf_err_q, inf_err_d, inf_last_q, inf_last_d;
  logic [1:0][DATA_W-1:0] buf_data_q, buf_data_d;
  logic [1:0][PORT_W-1:0] buf_port_q, buf_port_d;
  logic [1:0] buf_last_q, buf_last_d, buf_err_q, buf_err_d;
  logic rd_ptr_q, rd_ptr_d, wr_ptr;
  logic [1:0] cnt_q, cnt_d, cfg_resp;
  logic [ADDR_W:0] rd_addr;
  logic oob, is_last, pop, can_issue, cfg_ok;

  rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_arb (
    .req(req_valid), .ptr(rr_ptr_q), .gnt(gnt), .idx(gnt_idx), .any(gnt_any)
  );

  assign new_len   = req_len[gnt_idx*LEN_W +: LEN_W];
  assign rd_addr   = {1'b0, base_q} + (ADDR_W + 1)'(idx_q);
  assign oob       = rd_addr >= NSYN;
  assign is_last   = idx_q == len_q - LEN_W'(1);
  assign cfg_resp  = {1'b0, cfg_addr} < NSYN ? RESP_OKAY : RESP_SLVERR;
  assign cfg_ok    = cfg_resp == RESP_OKAY;
  assign rsp_valid = cnt_q != 2'd0;
  assign rsp_data  = buf_data_q[rd_ptr_q];
  assign rsp_port  = buf_port_q[rd_ptr_q];
  assign rsp_last  = buf_last_q[rd_ptr_q];
  assign rsp_err   = buf_err_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;
  assign wr_ptr    = rd_ptr_q ^ cnt_q[0];
  // a slot freed by this cycle's pop is already available to a new issue
  assign can_issue = 3'(cnt_q) + 3'(inf_v_q) - 3'(pop) < 3'd2;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    port_d     = port_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    inf_v_d    = 1'b0;
    inf_err_d  = 1'b0;
    inf_last_d = 1'b0;
    req_ready  = '0;
    cfg_ready  = 1'b0;
    cfg_err    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE:
        if (cfg_valid) state_d = CFG;
        else if (gnt_any) begin
          req_ready = gnt;
          port_d    = gnt_idx;
          base_d    = req_base[gnt_idx*ADDR_W +: ADDR_W];
          len_d     = new_len;
          idx_d     = '0;
          rr_ptr_d  = gnt_idx == PORT_W'(NUM_PORTS - 1) ? '0 : gnt_idx + PORT_W'(1);
          state_d   = new_len == '0 ? IDLE : BURST;
        end
      CFG: begin
        cfg_ready = 1'b1;
        cfg_err   = !cfg_ok;
        mem_en    = cfg_ok;
        mem_we    = cfg_ok;
        mem_addr  = cfg_ok ? cfg_addr : '0;
        mem_wdata = cfg_ok ? cfg_data : '0;
        state_d   = IDLE;
      end
      BURST:
        if (can_issue) begin
          // out-of-range beats skip the RAM but ride the in-flight slot to keep order
          mem_en     = !oob;
          mem_addr   = oob ? '0 : rd_addr[ADDR_W-1:0];
          inf_v_d    = 1'b1;
          inf_err_d  = oob;
          inf_last_d = is_last;
          idx_d      = idx_q + LEN_W'(1);
          state_d    = is_last ? DRAIN : BURST;
        end
      DRAIN:
        if (cnt_q == 2'd0 && !inf_v_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_data_d = buf_data_q;
    buf_port_d = buf_port_q;
    buf_last_d = buf_last_q;
    buf_err_d  = buf_err_q;
    if (inf_v_q) begin
      buf_data_d[wr_ptr] = inf_err_q ? '0 : mem_rdata;
      buf_port_d[wr_ptr] = port_q;
      buf_last_d[wr_ptr] = inf_last_q;
      buf_err_d[wr_ptr]  = inf_err_q;
    end
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(inf_v_q) - 2'(pop);
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      port_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      inf_v_q    <= 1'b0;
      inf_err_q  <= 1'b0;
      inf_last_q <= 1'b0;
      buf_data_q <= '0;
      buf_port_q <= '0;
      buf_last_q <= '0;
      buf_err_q  <= '0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      port_q     <= port_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      inf_v_q    <= inf_v_d;
      inf_err_q  <= inf_err_d;
      inf_last_q <= inf_last_d;
      buf_data_q <= buf_data_d;
      buf_port_q <= buf_port_d;
      buf_last_q <= buf_last_d;
      buf_err_q  <= buf_err_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
endmodule

// File: doc/synapse_fetch_scheduler.md
Name: synapse_fetch_scheduler

Overview:
- Sequences and shares the single-port synaptic weight RAM between one configuration-write requester and NUM_PORTS neuron-core burst-read requesters.
- Each core request names a base synapse index and a length. The block streams that many 16-bit weights back, tagged with the requesting port.
- Sits between the AXI4-Lite weight-programming path (config side) and the neuron cores' spike-processing pipelines (read side).
- Owns the RAM enable, write-enable and address.

Parameters:
NUM_PORTS, 4, number of neuron-core read requesters
NUM_SYNAPSES, 72401, weight RAM depth
ADDR_W, 17, synapse index width (must satisfy 2^ADDR_W >= NUM_SYNAPSES)
DATA_W, 16, weight width
LEN_W, 8, burst length field width
PORT_W, 2, port tag width (clog2 NUM_PORTS)

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted (single-cycle pulse)
cfg_addr  in  ADDR_W  config write synapse index
cfg_data  in  DATA_W  config write weight
cfg_err  out  1  accepted address was out of range (valid with cfg_ready)
req_valid  in  NUM_PORTS  per-port burst request
req_ready  out  NUM_PORTS  per-port request accepted (one-hot pulse)
req_base  in  NUM_PORTS*ADDR_W  per-port base index (packed, port 0 in LSBs)
req_len  in  NUM_PORTS*LEN_W  per-port burst length
rsp_valid  out  1  weight beat valid
rsp_ready  in  1  downstream accepts beat
rsp_data  out  DATA_W  weight
rsp_port  out  PORT_W  owning port
rsp_last  out  1  final beat of burst
rsp_err  out  1  beat index was out of range (rsp_data = 0)
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_en && !mem_we

Behaviour:
Clock and reset:
- Single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0; round-robin pointer 0; output buffer empty; in-flight flag 0; state IDLE.
- Reset mid-burst aborts the burst. No beat of that burst appears after reset deasserts.

States:
- IDLE:
  - If cfg_valid: go to CFG.
  - Else if any req_valid: grant the first requesting port at or after rr_ptr (wrapping). Pulse its req_ready. Latch base, len and port. Set rr_ptr = grant+1 mod NUM_PORTS. Go to BURST.
  - Config has priority only at this decision point. It never preempts an active burst.
- CFG (1 cycle):
  - Pulse cfg_ready.
  - If cfg_addr < NUM_SYNAPSES: mem_en=1, mem_we=1. Otherwise no RAM access and cfg_err=1.
  - Return to IDLE.
- BURST:
  - Issue one read per cycle while (buffer occupancy + in-flight) < 2. Address = base + beat counter.
  - Beat index >= NUM_SYNAPSES: no RAM access. A beat with data 0 and rsp_err=1 enters the buffer directly, in order.
  - After the last issue, go to DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight, then go to IDLE.

Burst length and ordering:
- len = 0: req_ready still pulses, no beats are produced, and the FSM returns to IDLE next cycle.
- Bursts never interleave. Beats arrive in index order.
- Base + index is computed ADDR_W+1 bits wide, so there is no wrap.

Output buffer and latency:
- 2-entry FIFO. Head drives rsp_*. A beat pops when rsp_valid && rsp_ready.
- rsp_ready may drop at any time without losing data.
- rsp_last is set on beat len-1.
- Latency: req_valid accepted at cycle T (IDLE) -> mem read issued T+1 -> first rsp_valid at T+3.
- With rsp_ready held high, throughput is 1 beat/cycle.

Decomposition:
- Shared package synapse_mem_pkg holds:
  - fetch_state_t enum (IDLE, CFG, BURST, DRAIN)
  - NUM_SYNAPSES_DEFAULT, WEIGHT_W=16
  - resp codes matching the AXI OKAY/SLVERR usage
- One sub-module: rr_arbiter (NUM_PORTS request vector + pointer -> one-hot grant + index, combinational with registered pointer update in the parent).

Test Plan:
- Config write: cfg_addr=5, data=0x1234, then port0 base=5 len=1 -> one beat data 0x1234, port 0, last=1, err=0, first rsp_valid 3 cycles after acceptance.
- Round-robin fairness: all 4 ports request continuously with len=2 -> grant order 0,1,2,3,0. Each burst emits 2 beats with last on the 2nd.
- Backpressure: port1 base=10 len=8, rsp_ready toggled 1,0,0,1 repeating -> all 8 beats delivered in order (indices 10..17), none dropped or duplicated. mem issues never exceed 2 outstanding.
- Boundary: port2 base=72399 len=4 -> beats 0,1 carry RAM data with err=0. Beats 2,3 carry data=0 with err=1, and no mem_en is issued for them. cfg write to 72401 -> cfg_ready with cfg_err=1, mem_en=0.
- Priority and simultaneity: cfg_valid and req_valid[3] asserted together in IDLE -> CFG first, then port3 granted. cfg_valid asserted mid-burst -> waits until DRAIN completes.
- Reset mid-operation and len=0: rst for 1 cycle during beat 3 of a len=6 burst -> rsp_valid=0 next cycle, no further beats. Subsequent port0 len=0 -> req_ready pulse, no beats, IDLE next cycle.
